// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared symbol geometry, idle pattern and sequencer states
package serdes_pkg;

  localparam int SYM_W = 10;
  localparam int NCH = 3;
  localparam int SYNC_SYMS = 16;
  localparam logic [SYM_W-1:0] IDLE_SYM = 10'b1101010100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/symbol_phase_cnt.sv
// rtl/symbol_phase_cnt.sv - free-running bit phase within a symbol, load on last bit
module symbol_phase_cnt #(
  parameter int SYM_W = serdes_pkg::SYM_W
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] bit_idx,
  output logic       load
);

  assign load = (bit_idx == 4'(SYM_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx <= '0;
    end else if (load) begin
      bit_idx <= '0;
    end else begin
      bit_idx <= bit_idx + 4'd1;
    end
  end

endmodule

// File: rtl/serdes_sequencer.sv
// rtl/serdes_sequencer.sv - lockstep multi-lane symbol sequencer: idle, sync preamble, data run
module serdes_sequencer #(
  parameter int SYM_W = serdes_pkg::SYM_W,
  parameter int NCH = serdes_pkg::NCH,
  parameter int SYNC_SYMS = serdes_pkg::SYNC_SYMS,
  parameter logic [SYM_W-1:0] IDLE_SYM = serdes_pkg::IDLE_SYM
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 s_valid,
  input  logic [NCH*SYM_W-1:0] s_data,
  output logic                 s_ready,
  output logic [NCH*SYM_W-1:0] sym_out,
  output logic [3:0]           bit_idx,
  output logic                 load,
  output logic                 link_up,
  output logic                 underflow,
  output logic [15:0]          underflow_cnt,
  input  logic                 clr_stats
);
  import serdes_pkg::*;

  localparam int DW = NCH * SYM_W;
  localparam int SC_W = (SYNC_SYMS > 1) ? $clog2(SYNC_SYMS) : 1;
  localparam logic [DW-1:0] IDLE_GRP = {NCH{IDLE_SYM}};

  seq_state_e      state, state_nx;
  logic [SC_W-1:0] sync_cnt, sync_cnt_nx;
  logic [DW-1:0]   sym_nx;
  logic [DW-1:0]   hold_data, hold_data_nx;
  logic            hold_full, hold_full_nx;
  logic            accept;
  logic            uf_evt;

  symbol_phase_cnt #(.SYM_W(SYM_W)) u_phase (
    .clk     (clk),
    .rst     (rst),
    .bit_idx (bit_idx),
    .load    (load)
  );

  assign link_up = (state == RUN);
  assign s_ready = (state == RUN) && (!hold_full || load);
  assign accept  = s_valid && s_ready;

  always_comb begin
    state_nx     = state;
    sync_cnt_nx  = sync_cnt;
    sym_nx       = sym_out;
    hold_full_nx = hold_full;
    hold_data_nx = hold_data;
    uf_evt       = 1'b0;

    if (accept) begin
      hold_full_nx = 1'b1;
      hold_data_nx = s_data;
    end

    if (load) begin
      if (!accept) hold_full_nx = 1'b0;
      case (state)
        IDLE: begin
          sym_nx = IDLE_GRP;
          if (enable) begin
            state_nx    = SYNC;
            sync_cnt_nx = '0;
          end
        end
        SYNC: begin
          sym_nx = IDLE_GRP;
          if (!enable) begin
            state_nx     = IDLE;
            hold_full_nx = 1'b0;
          end else if (sync_cnt == SC_W'(SYNC_SYMS - 1)) begin
            state_nx = RUN;
          end else begin
            sync_cnt_nx = sync_cnt + SC_W'(1);
          end
        end
        RUN: begin
          // Dropping the link discards anything buffered, including a group accepted on this edge.
          if (!enable) begin
            state_nx     = IDLE;
            sym_nx       = IDLE_GRP;
            hold_full_nx = 1'b0;
          end else if (hold_full) begin
            sym_nx = hold_data;
          end else begin
            sym_nx = IDLE_GRP;
            uf_evt = 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          sym_nx   = IDLE_GRP;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sync_cnt  <= '0;
      sym_out   <= IDLE_GRP;
      hold_full <= 1'b0;
      hold_data <= '0;
      underflow <= 1'b0;
    end else begin
      state     <= state_nx;
      sync_cnt  <= sync_cnt_nx;
      sym_out   <= sym_nx;
      hold_full <= hold_full_nx;
      hold_data <= hold_data_nx;
      underflow <= uf_evt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow_cnt <= '0;
    end else if (clr_stats) begin
      underflow_cnt <= '0;
    end else if (uf_evt && (underflow_cnt != 16'hFFFF)) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_serdes_sequencer.sv
// tb/tb_serdes_sequencer.sv - scoreboard bench for serdes_sequencer
module tb_serdes_sequencer;

  localparam logic [9:0]  IDLE_S = 10'b1101010100;
  localparam logic [29:0] IDLE_GRP = {IDLE_S, IDLE_S, IDLE_S};

  logic        clk, rst, enable, s_valid, s_ready, load, link_up, underflow, clr_stats;
  logic [29:0] s_data, sym_out;
  logic [3:0]  bit_idx;
  logic [15:0] underflow_cnt;

  // narrow instance: one-bit symbols so every cycle is a boundary
  logic        rst_f, en_f, clr_f, rdy_f, load_f, link_f, uf_f, sdata_f, sym_f;
  logic [3:0]  bidx_f;
  logic [15:0] ucnt_f;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [29:0] sym;
    logic        link;
    logic        uf;
    logic [15:0] cnt;
  } exp_t;
  exp_t exp_q[$];
  logic prev_load = 1'b0;

  serdes_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .sym_out(sym_out), .bit_idx(bit_idx), .load(load),
    .link_up(link_up), .underflow(underflow), .underflow_cnt(underflow_cnt),
    .clr_stats(clr_stats)
  );

  serdes_sequencer #(.SYM_W(1), .NCH(1), .SYNC_SYMS(1), .IDLE_SYM(1'b0)) dut_f (
    .clk(clk), .rst(rst_f), .enable(en_f), .s_valid(1'b0), .s_data(sdata_f),
    .s_ready(rdy_f), .sym_out(sym_f), .bit_idx(bidx_f), .load(load_f),
    .link_up(link_f), .underflow(uf_f), .underflow_cnt(ucnt_f),
    .clr_stats(clr_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [29:0] grp(input int n);
    logic [9:0] v;
    v = 10'(n);
    return {v, v, v};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [29:0] s, input logic l, input logic u, input logic [15:0] c);
    exp_t e;
    e.sym = s; e.link = l; e.uf = u; e.cnt = c;
    exp_q.push_back(e);
  endtask

  // monitor: every symbol boundary presents a new symbol, compared against the queue
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_load = 1'b0;
    end else begin
      if (prev_load) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL boundary_unexpected: got sym %0h with nothing expected", sym_out);
        end else begin
          e = exp_q.pop_front();
          if (sym_out !== e.sym || link_up !== e.link || underflow !== e.uf ||
              underflow_cnt !== e.cnt || bit_idx !== 4'd0) begin
            n_bad++;
            $display("FAIL boundary: got sym %0h link %0b uf %0b cnt %0h bit %0d, expected sym %0h link %0b uf %0b cnt %0h bit 0",
                     sym_out, link_up, underflow, underflow_cnt, bit_idx, e.sym, e.link, e.uf, e.cnt);
          end
        end
      end
      prev_load = load;
    end
  end

  initial begin
    int n;
    logic rdy_exp;
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0; clr_stats = 1'b0;
    rst_f = 1'b1; en_f = 1'b0; clr_f = 1'b0; sdata_f = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bit_idx", 32'(bit_idx), 32'd0);
    chk("rst_sym_out", 32'(sym_out), 32'(IDLE_GRP));
    chk("rst_link_up", 32'(link_up), 32'd0);
    chk("rst_underflow_cnt", 32'(underflow_cnt), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);

    // link disabled: idle symbols, loads every 10th cycle
    rst = 1'b0;
    for (int i = 0; i < 4; i++) push(IDLE_GRP, 1'b0, 1'b0, 16'd0);
    for (int c = 0; c < 40; c++) begin
      chk("load_phase", 32'(load), 32'(c % 10 == 9));
      chk("s_ready_idle", 32'(s_ready), 32'd0);
      @(negedge clk);
    end

    // sync preamble, RUN entry without underflow, then first underflow
    enable = 1'b1;
    for (int i = 0; i < 16; i++) push(IDLE_GRP, 1'b0, 1'b0, 16'd0);
    push(IDLE_GRP, 1'b1, 1'b0, 16'd0);
    push(IDLE_GRP, 1'b1, 1'b1, 16'd1);
    repeat (180) @(negedge clk);

    // streaming data: one group per boundary, s_ready only on loads after first fill
    s_valid = 1'b1; n = 1; s_data = grp(1);
    for (int k = 1; k <= 4; k++) push(grp(k), 1'b1, 1'b0, 16'd1);
    for (int c = 220; c < 263; c++) begin
      rdy_exp = (c == 220) || (c % 10 == 9);
      chk("s_ready_stream", 32'(s_ready), 32'(rdy_exp));
      @(negedge clk);
      if (rdy_exp) begin
        n++;
        s_data = grp(n);
      end
    end

    // drop enable mid-symbol with buffer full
    chk("bit_idx_at_drop", 32'(bit_idx), 32'd3);
    enable = 1'b0;
    push(IDLE_GRP, 1'b0, 1'b0, 16'd1);
    push(IDLE_GRP, 1'b0, 1'b0, 16'd1);
    repeat (7) @(negedge clk);
    chk("s_ready_after_drop", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    repeat (10) @(negedge clk);

    // relink: the discarded group must not reappear at RUN entry
    enable = 1'b1;
    for (int i = 0; i < 16; i++) push(IDLE_GRP, 1'b0, 1'b0, 16'd1);
    push(IDLE_GRP, 1'b1, 1'b0, 16'd1);
    push(IDLE_GRP, 1'b1, 1'b1, 16'd2);
    repeat (185) @(negedge clk);

    // asynchronous reset mid-symbol in RUN
    chk("bit_idx_pre_rst", 32'(bit_idx), 32'd5);
    chk("link_up_pre_rst", 32'(link_up), 32'd1);
    rst = 1'b1; enable = 1'b0;
    #1;
    chk("arst_bit_idx", 32'(bit_idx), 32'd0);
    chk("arst_link_up", 32'(link_up), 32'd0);
    chk("arst_sym_out", 32'(sym_out), 32'(IDLE_GRP));
    chk("arst_underflow_cnt", 32'(underflow_cnt), 32'd0);
    chk("arst_underflow", 32'(underflow), 32'd0);
    chk("arst_s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push(IDLE_GRP, 1'b0, 1'b0, 16'd0);
    for (int k = 0; k < 10; k++) begin
      chk("load_after_rst", 32'(load), 32'(k == 9));
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    rst = 1'b1;

    // counter saturation: 70000 underflows on the one-bit instance
    @(negedge clk);
    rst_f = 1'b0; en_f = 1'b1;
    repeat (70002) @(negedge clk);
    chk("f_link_up", 32'(link_f), 32'd1);
    chk("f_underflow_pulse", 32'(uf_f), 32'd1);
    chk("f_underflow_cnt_sat", 32'(ucnt_f), 32'hFFFF);
    clr_f = 1'b1;
    @(negedge clk);
    chk("f_clr_beats_inc", 32'(ucnt_f), 32'd0);
    clr_f = 1'b0;
    @(negedge clk);
    chk("f_cnt_after_clr", 32'(ucnt_f), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
